wordle_guess_ctrl: RTL

WORDLE_GUESS_CTRL -- requirements
Module: wordle_guess_ctrl

---
 rtl/wordle_guess_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/wordle_guess_ctrl.sv
// Wordle guess controller: letter entry, two-pass green/yellow scoring,
// and serial board-memory write-back of each scored row.
module wordle_guess_ctrl #(
  parameter int N_GUESS = 6
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        start,
  input  logic [24:0] target_word,
  input  logic        letter_valid,
  input  logic [4:0]  letter,
  input  logic        backspace,
  input  logic        submit,
  output logic        wr_en,
  output logic [2:0]  wr_row,
  output logic [2:0]  wr_col,
  output logic [4:0]  wr_letter,
  output logic [1:0]  wr_color,
  output logic [2:0]  guess_num,
  output logic        busy,
  output logic        invalid,
  output logic        win,
  output logic        lose
);

  typedef enum logic [2:0] {
    IDLE, ENTRY, GREEN, YELLOW, WRITE, CHECK, DONE
  } state_t;

  localparam logic [4:0] BLANK = 5'd31;
  localparam logic [2:0] LAST_GUESS = 3'(N_GUESS);

  state_t          state, state_n;
  logic [2:0]      col, col_n;
  logic [2:0]      pos, pos_n;
  logic [2:0]      gnum_n;
  logic [4:0][4:0] gbuf, gbuf_n;
  logic [4:0][4:0] tgt, tgt_n;
  logic [4:0][1:0] clr, clr_n;
  logic [4:0]      used, used_n;
  logic            wen_n, inv_n, win_n, lose_n, busy_n;
  logic [2:0]      wrow_n, wcol_n;
  logic [4:0]      wlet_n;
  logic [1:0]      wclr_n;
  logic            hit;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      col       <= '0;
      pos       <= '0;
      gbuf      <= '0;
      tgt       <= '0;
      clr       <= '0;
      used      <= '0;
      guess_num <= '0;
      wr_en     <= 1'b0;
      wr_row    <= '0;
      wr_col    <= '0;
      wr_letter <= '0;
      wr_color  <= '0;
      busy      <= 1'b0;
      invalid   <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      pos       <= pos_n;
      gbuf      <= gbuf_n;
      tgt       <= tgt_n;
      clr       <= clr_n;
      used      <= used_n;
      guess_num <= gnum_n;
      wr_en     <= wen_n;
      wr_row    <= wrow_n;
      wr_col    <= wcol_n;
      wr_letter <= wlet_n;
      wr_color  <= wclr_n;
      busy      <= busy_n;
      invalid   <= inv_n;
      win       <= win_n;
      lose      <= lose_n;
    end
  end

  always_comb begin
    state_n = state;
    col_n   = col;
    pos_n   = pos;
    gnum_n  = guess_num;
    gbuf_n  = gbuf;
    tgt_n   = tgt;
    clr_n   = clr;
    used_n  = used;
    wen_n   = 1'b0;
    inv_n   = 1'b0;
    win_n   = win;
    lose_n  = lose;
    wrow_n  = '0;
    wcol_n  = '0;
    wlet_n  = '0;
    wclr_n  = '0;
    hit     = 1'b0;
    if (start) begin
      state_n = ENTRY;
      tgt_n   = target_word;
      gbuf_n  = '0;
      col_n   = '0;
      gnum_n  = '0;
      win_n   = 1'b0;
      lose_n  = 1'b0;
    end else begin
      unique case (state)
        ENTRY: begin
          if (submit) begin
            if (col == 3'd5) begin
              state_n = GREEN;
            end else begin
              inv_n = 1'b1;
            end
          end else if (backspace) begin
            if (col != 3'd0) begin
              col_n         = col - 3'd1;
              gbuf_n[col_n] = BLANK;
              wen_n         = 1'b1;
              wrow_n        = guess_num;
              wcol_n        = col_n;
              wlet_n        = BLANK;
            end
          end else if (letter_valid) begin
            if (col != 3'd5) begin
              gbuf_n[col] = letter;
              col_n       = col + 3'd1;
              wen_n       = 1'b1;
              wrow_n      = guess_num;
              wcol_n      = col;
              wlet_n      = letter;
            end
          end
        end
        GREEN: begin
          clr_n  = '0;
          used_n = '0;
          for (int i = 0; i < 5; i++) begin
            if (gbuf[i] == tgt[i]) begin
              clr_n[i]  = 2'b11;
              used_n[i] = 1'b1;
            end
          end
          pos_n   = '0;
          state_n = YELLOW;
        end
        YELLOW: begin
          // Lowest unused target slot with the same letter is consumed.
          if (clr[pos] != 2'b11) begin
            clr_n[pos] = 2'b01;
            for (int i = 0; i < 5; i++) begin
              if (!hit && !used[i] && tgt[i] == gbuf[pos]) begin
                hit        = 1'b1;
                used_n[i]  = 1'b1;
                clr_n[pos] = 2'b10;
              end
            end
          end
          if (pos == 3'd4) begin
            state_n = WRITE;
            pos_n   = '0;
            wen_n   = 1'b1;
            wrow_n  = guess_num;
            wcol_n  = '0;
            wlet_n  = gbuf[0];
            wclr_n  = clr[0];
          end else begin
            pos_n = pos + 3'd1;
          end
        end
        WRITE: begin
          if (pos == 3'd4) begin
            state_n = CHECK;
            gnum_n  = guess_num + 3'd1;
          end else begin
            pos_n  = pos + 3'd1;
            wen_n  = 1'b1;
            wrow_n = guess_num;
            wcol_n = pos_n;
            wlet_n = gbuf[pos_n];
            wclr_n = clr[pos_n];
          end
        end
        CHECK: begin
          if (clr == '1) begin
            win_n   = 1'b1;
            state_n = DONE;
          end else if (guess_num == LAST_GUESS) begin
            lose_n  = 1'b1;
            state_n = DONE;
          end else begin
            col_n   = '0;
            gbuf_n  = '0;
            state_n = ENTRY;
          end
        end
        default: ;
      endcase
    end
    busy_n = (state_n == GREEN) || (state_n == YELLOW) ||
             (state_n == WRITE) || (state_n == CHECK);
  end

endmodule
